// File: rtl/cfg_bitstream_router.sv
// Serial configuration bitstream router: decodes a per-frame CLB index header, buffers one
// payload and bursts it gap-free to the addressed CLB after a one-cycle lead strobe.
module cfg_bitstream_router #(
  parameter int unsigned NUM_CLBS     = 6,
  parameter int unsigned CLB_CFG_BITS = 38
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_start_i,
  input  logic                bs_valid_i,
  input  logic                bs_data_i,
  output logic                bs_ready_o,
  output logic [NUM_CLBS-1:0] cfg_clb_o,
  output logic                cfg_clb_data_o,
  output logic                cfg_busy_o,
  output logic                cfg_done_o,
  output logic                cfg_err_o
);

  localparam int unsigned CLB_IDX_W   = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1;
  localparam int unsigned FRAME_CNT_W = $clog2(NUM_CLBS + 1);
  localparam int unsigned HDR_CNT_W   = $clog2(CLB_IDX_W) + 1;
  localparam int unsigned BIT_CNT_W   = $clog2(CLB_CFG_BITS) + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr   = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StPrime = 3'd3;
  localparam logic [2:0] StBurst = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  localparam logic [HDR_CNT_W-1:0]   HdrLast   = HDR_CNT_W'(CLB_IDX_W - 1);
  localparam logic [BIT_CNT_W-1:0]   BitLast   = BIT_CNT_W'(CLB_CFG_BITS - 1);
  localparam logic [FRAME_CNT_W-1:0] FrameLast = FRAME_CNT_W'(NUM_CLBS - 1);
  localparam logic [CLB_IDX_W:0]     IdxLimit  = (CLB_IDX_W + 1)'(NUM_CLBS);

  logic [2:0]              state_q, state_d;
  logic [HDR_CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CLB_IDX_W-1:0]    idx_q, idx_d;
  logic [CLB_CFG_BITS-1:0] buf_q, buf_d;

  logic                 xfer;
  logic                 strobe;
  logic [CLB_IDX_W-1:0] idx_next;

  assign xfer = bs_valid_i & bs_ready_o;

  // Header arrives MSB first, so each new bit enters at the LSB.
  always_comb begin
    idx_next    = '0;
    idx_next[0] = bs_data_i;
    for (int i = 1; i < int'(CLB_IDX_W); i++) begin
      idx_next[i] = idx_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    if (cfg_start_i) begin
      state_d     = StHdr;
      hdr_cnt_d   = '0;
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      idx_d       = '0;
      buf_d       = '0;
    end else begin
      case (state_q)
        StHdr: begin
          if (xfer) begin
            idx_d = idx_next;
            if (hdr_cnt_q == HdrLast) begin
              hdr_cnt_d = '0;
              state_d   = ({1'b0, idx_next} >= IdxLimit) ? StErr : StLoad;
            end else begin
              hdr_cnt_d = hdr_cnt_q + 1'b1;
            end
          end
        end
        StLoad: begin
          // First payload bit ends up in buf_q[0] and is the first one emitted.
          if (xfer) begin
            buf_d = {bs_data_i, buf_q[CLB_CFG_BITS-1:1]};
            if (bit_cnt_q == BitLast) begin
              bit_cnt_d = '0;
              state_d   = StPrime;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StPrime: begin
          state_d = StBurst;
        end
        StBurst: begin
          buf_d = {1'b0, buf_q[CLB_CFG_BITS-1:1]};
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = (frame_cnt_q == FrameLast) ? StDone : StHdr;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      hdr_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
    end
  end

  assign strobe         = (state_q == StPrime) || (state_q == StBurst);
  assign bs_ready_o     = (state_q == StHdr) || (state_q == StLoad);
  assign cfg_clb_data_o = (state_q == StBurst) & buf_q[0];
  assign cfg_busy_o     = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
  assign cfg_done_o     = (state_q == StDone);
  assign cfg_err_o      = (state_q == StErr);

  always_comb begin
    cfg_clb_o = '0;
    for (int i = 0; i < int'(NUM_CLBS); i++) begin
      cfg_clb_o[i] = strobe && (idx_q == CLB_IDX_W'(i));
    end
  end

endmodule
